// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and the blocks that
// address the data memory (loader, MMIO decode).
package dmem_arbiter_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] ARB   = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    // RAM occupies words 0..RAM_WORDS-1; MMIO words sit directly above it
    localparam int RAM_WORDS     = 512;
    localparam int MMIO_LED_WORD = RAM_WORDS;
    localparam int MMIO_SEG_WORD = RAM_WORDS + 1;

    // Word accesses only: any nonzero low address bits is a misaligned access
    function automatic logic misaligned(input logic [1:0] low);
        return low != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational 2-way round-robin picker. force_mask bit = 1 means that
// port is eligible; on a conflict the port that did not win last time wins.
module dmem_rr_pick (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    input  logic [1:0] force_mask,
    output logic [1:0] gnt
);

    logic elig0;
    logic elig1;

    // One-hot grant; last=1 means port 1 won previously, so port 0 wins a tie
    always_comb begin
        elig0  = req0 & force_mask[0];
        elig1  = req1 & force_mask[1];
        gnt[0] = elig0 & (~elig1 | last);
        gnt[1] = elig1 & (~elig0 | ~last);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory. Port 0 is the
// pipeline MEM stage, port 1 the debug/loader engine. Round-robin with an
// optional bus lock, a lock watchdog, and registered read-data return.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = 16,
    parameter int AW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] wdata0,
    input  logic [AW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] mem_rdata,
    output logic          gnt0,
    output logic          gnt1,
    output logic [AW-1:0] rdata0,
    output logic [AW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          err0,
    output logic          err1,
    output logic          lock_timeout,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [1:0]    state;
    logic          last;
    logic [CW-1:0] lock_cnt;
    logic [1:0]    allow;
    logic [1:0]    pick;
    logic [1:0]    gnt;
    logic [AW-1:0] sel_addr;
    logic [AW-1:0] sel_wdata;
    logic          sel_we;
    logic          any_gnt;
    logic          bad_align;

    // While locked only the owner is eligible
    always_comb begin
        case (state)
            LOCK0:   allow = 2'b01;
            LOCK1:   allow = 2'b10;
            default: allow = 2'b11;
        endcase
    end

    dmem_rr_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last       (last),
        .force_mask (allow),
        .gnt        (pick)
    );

    // Grants are suppressed for as long as reset is held low
    assign gnt  = reset ? pick : 2'b00;
    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // Route the granted port to the memory; misaligned accesses reach the
    // memory address lines but never strobe read or write
    always_comb begin
        sel_addr  = gnt[1] ? addr1  : addr0;
        sel_wdata = gnt[1] ? wdata1 : wdata0;
        sel_we    = gnt[1] ? we1    : we0;
        any_gnt   = |gnt;
        bad_align = misaligned(sel_addr[1:0]);
        mem_addr  = any_gnt ? sel_addr  : '0;
        mem_wdata = any_gnt ? sel_wdata : '0;
        mem_read  = any_gnt & ~bad_align & ~sel_we;
        mem_write = any_gnt & ~bad_align &  sel_we;
    end

    // Arbitration state, round-robin history and lock watchdog
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARB;
            last         <= 1'b1;
            lock_cnt     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            if (any_gnt) begin
                last <= gnt[1];
            end
            case (state)
                ARB: begin
                    if (gnt[0] && lock0) begin
                        state    <= LOCK0;
                        lock_cnt <= CW'(1);
                    end else if (gnt[1] && lock1) begin
                        state    <= LOCK1;
                        lock_cnt <= CW'(1);
                    end
                end
                LOCK0, LOCK1: begin
                    // A voluntary release wins over the watchdog in the same cycle
                    if ((state == LOCK0 && !lock0) || (state == LOCK1 && !lock1)) begin
                        state    <= ARB;
                        lock_cnt <= '0;
                    end else if (lock_cnt == CW'(LOCK_MAX)) begin
                        state        <= ARB;
                        lock_cnt     <= '0;
                        lock_timeout <= 1'b1;
                        last         <= (state == LOCK1);
                    end else begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= ARB;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    // Registered read return and one-cycle valid/error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
        end else begin
            rvalid0 <= gnt[0] & ~bad_align & ~we0;
            rvalid1 <= gnt[1] & ~bad_align & ~we1;
            err0    <= gnt[0] & bad_align;
            err1    <= gnt[1] & bad_align;
            if (gnt[0] && !bad_align && !we0) begin
                rdata0 <= mem_rdata;
            end
            if (gnt[1] && !bad_align && !we1) begin
                rdata1 <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory (512 words, combinational read, write on clk edge, MMIO words for LEDs and 7-seg above RAM) between two requesters.
- Port 0 is the pipeline MEM stage; port 1 is the debug/loader engine.
- Round-robin arbitration with an optional bus lock for port bursts, and registered read-data return.
- A lock watchdog and misalignment checks are included.

Parameters:
- LOCK_MAX, 16, maximum consecutive locked cycles before forced release (>=2).
- AW, 32, address/data width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req0/req1  in  1  port request; held high until gnt seen
- we0/we1  in  1  1=write, 0=read
- addr0/addr1  in  32  byte address
- wdata0/wdata1  in  32  write data
- lock0/lock1  in  1  keep ownership after this grant
- gnt0/gnt1  out  1  combinational grant; access executes on this clk edge
- rdata0/rdata1  out  32  registered read data
- rvalid0/rvalid1  out  1  one-cycle pulse, cycle after a read grant
- err0/err1  out  1  one-cycle pulse, cycle after a misaligned grant
- lock_timeout  out  1  sticky flag, cleared only by reset
- mem_addr  out  32  to memory Address
- mem_wdata  out  32  to memory Write_data
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite

Behaviour:
- Reset (reset=0, async):
  - state=ARB, last=1 (port 0 wins the first conflict), lock_cnt=0.
  - rdata*=0, rvalid*=0, err*=0, lock_timeout=0.
  - gnt*, mem_read and mem_write are 0 while reset is low.
- FSM states: ARB, LOCK0, LOCK1.
- ARB:
  - One request: grant it.
  - Both request: grant the port != last.
  - On a grant, last<=granted port. If the granted port's lock=1, go to LOCKx and set lock_cnt<=1.
- LOCKx:
  - Only port x may be granted; the other port's gnt=0 regardless of req.
  - lock_cnt increments every cycle in LOCKx.
  - Exit to ARB on the first edge where lockx=0, whether or not reqx is high. A granted access in that cycle still completes.
  - Exit to ARB if lock_cnt==LOCK_MAX. This sets lock_timeout=1 and last<=x so the other port wins next.
- Memory drive (combinational, from the granted port):
  - mem_addr=addr, mem_wdata=wdata, mem_write=we, mem_read=~we.
  - With no grant: all zero.
- Misaligned grant (addr[1:0]!=0):
  - gnt still asserts and the request is consumed.
  - mem_read=mem_write=0, so no memory side effect.
  - Next cycle: errx=1, rvalidx=0, rdatax unchanged.
- Read grant: rdatax<=memory Mem_data at the grant edge, and rvalidx=1 for exactly the next cycle.
- Write grant: no rvalid; the memory updates on that edge.
- Latency and throughput:
  - Zero-cycle grant when uncontended.
  - One access per cycle total.
  - Back-to-back grants to the same port are allowed when the other port is idle.
- Fairness: under continuous contention without lock, grants alternate 0,1,0,1.
- Reset mid-lock: the FSM returns to ARB immediately, and in-flight rvalid/err are dropped.
- req low in LOCKx: no grant, but the counter still runs (this is what lets the watchdog fire).

Decomposition:
- Shared package holds:
  - state encoding localparams (ARB=2'd0, LOCK0=2'd1, LOCK1=2'd2)
  - RAM_WORDS=512
  - MMIO word addresses for LEDs and 7-seg, also used by the loader
- One sub-module, dmem_rr_pick: a combinational 2-way round-robin picker taking req0, req1, last and force mask, and returning a one-hot grant.

Test Plan:
- Uncontended read: req0=1, we0=0, addr0=0x8 with memory word 2=112 → gnt0 same cycle, mem_read=1, mem_addr=0x8; next cycle rvalid0=1, rdata0=112.
- Contention: req0=req1=1 held for 4 cycles, both reads → gnt sequence 0,1,0,1; exactly one gnt per cycle; each port sees 2 rvalid pulses.
- Write then read: port 1 writes 0xDEADBEEF to 0x84, then port 0 reads 0x84 → rdata0=0xDEADBEEF; words 0..32 otherwise unchanged.
- Lock burst: port 1 lock1=1 for 5 writes while req0=1 → gnt0=0 for those 5 cycles; gnt0 in the cycle after lock1 drops; lock_timeout stays 0.
- Watchdog: LOCK_MAX=16, lock1 held high forever → forced exit after 16 locked cycles, lock_timeout=1, next contended grant goes to port 0.
- Misaligned access and reset: addr0=0x6 → gnt0=1, mem_read=mem_write=0, err0 pulse next cycle. Then assert reset low during LOCK0 → gnt* and rvalid* go to 0 immediately, and the FSM is in ARB after release.
